// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (open-drain pull-low requests)
// Define PS2_TX_RETRY_EN to re-send a frame once after a NACK or timeout.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int INH_CYC = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int CNT_W   = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, PARITY, STOP, ACK, WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic             err_flag_q, err_flag_d;
  logic             idle_seen_q, idle_seen_d;
  logic             retry_q, retry_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_err_q, tx_err_d;
  logic             busy_q, busy_d;
  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             dat_s1_q, dat_s2_q;
  logic             accept, fe, in_frame, timeout, restart;

  assign accept   = tx_valid && tx_ready_q;
  assign fe       = clk_prev_q && !clk_s2_q;
  assign in_frame = (state_q == SHIFT) || (state_q == PARITY) ||
                    (state_q == STOP)  || (state_q == ACK);
  assign timeout  = in_frame && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    parity_d    = parity_q;
    err_flag_d  = err_flag_q;
    idle_seen_d = idle_seen_q;
    retry_d     = retry_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    tx_done_d   = 1'b0;
    tx_err_d    = 1'b0;
    restart     = 1'b0;
    if (in_frame) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d     = tx_data;
          shift_d    = tx_data;
          parity_d   = ~^tx_data;
          err_flag_d = 1'b0;
          retry_d    = 1'b0;
          cnt_d      = '0;
          clk_oe_d   = 1'b1;
          data_oe_d  = 1'b0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REQ: begin
        // Start bit stays driven; releasing clock hands timing to the device.
        clk_oe_d  = 1'b0;
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (fe) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fe) begin
          data_oe_d = ~parity_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          data_oe_d = 1'b0;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (fe) begin
          idle_seen_d = 1'b0;
          state_d     = WAIT_IDLE;
          if (dat_s2_q) begin
            err_flag_d = 1'b1;
            tx_err_d   = !(RETRY_EN && !retry_q);
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          idle_seen_d = 1'b1;
          if (idle_seen_q) begin
            if (!err_flag_q) begin
              tx_done_d = 1'b1;
              state_d   = IDLE;
            end else if (RETRY_EN && !retry_q) begin
              restart = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          idle_seen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      if (RETRY_EN && !retry_q) begin
        restart = 1'b1;
      end else begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        tx_err_d  = 1'b1;
        state_d   = IDLE;
      end
    end

    if (restart) begin
      retry_d    = 1'b1;
      shift_d    = data_q;
      err_flag_d = 1'b0;
      cnt_d      = '0;
      clk_oe_d   = 1'b1;
      data_oe_d  = 1'b0;
      state_d    = INHIBIT;
    end

    // Ready returns one cycle after the frame's closing pulse.
    tx_ready_d = (state_q == IDLE) && (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      err_flag_q  <= 1'b0;
      idle_seen_q <= 1'b0;
      retry_q     <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      parity_q    <= parity_d;
      err_flag_q  <= err_flag_d;
      idle_seen_q <= idle_seen_d;
      retry_q     <= retry_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      tx_ready_q  <= tx_ready_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
      busy_q      <= busy_d;
      clk_s1_q    <= ps2_clk_i;
      clk_s2_q    <= clk_s1_q;
      clk_prev_q  <= clk_s2_q;
      dat_s1_q    <= ps2_data_i;
      dat_s2_q    <= dat_s1_q;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  localparam int H       = 20;
  localparam int INH_EXP = 2000;
  localparam int TO_EXP  = 5000;
  localparam int M_ACK    = 0;
  localparam int M_SILENT = 1;
  localparam int M_ABORT  = 2;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_line, ps2_data_line;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       dev_busy = 1'b0;
  int         dev_fe_cnt = 0;
  int         dev_mode = M_ACK;
  int         dev_nack_req = 0;
  logic [10:0] dev_bits;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int kind;
    bit chk_to;
  } res_t;

  typedef struct {
    logic [7:0] d;
    logic       par;
    int         mode;
    int         nack;
  } vec_t;

  res_t        res_q[$];
  logic [10:0] frame_q[$];

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ(100000000),
    .INHIBIT_US (20),
    .TIMEOUT_US (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_data_i (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Device: on request-to-send, clocks out 11 bits and samples data before each rising edge.
  initial begin : device
    int nacks_given;
    logic ack;
    nacks_given = 0;
    forever begin
      @(negedge clk);
      if (rst && !ps2_clk_oe && ps2_data_oe && dev_mode != M_SILENT) begin
        dev_fe_cnt = 0;
        dev_busy   = 1'b1;
        repeat (H) @(negedge clk);
        dev_bits    = '0;
        dev_bits[0] = ps2_data_line;
        for (int k = 1; k <= 10; k++) begin
          dev_clk_low = 1'b1;
          dev_fe_cnt++;
          repeat (H) @(negedge clk);
          dev_bits[k] = ps2_data_line;
          dev_clk_low = 1'b0;
          repeat (H) @(negedge clk);
        end
        ack = (nacks_given >= dev_nack_req);
        if (!ack) nacks_given++;
        dev_data_low = ack;
        dev_clk_low  = 1'b1;
        dev_fe_cnt++;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (H) @(negedge clk);
        dev_data_low = 1'b0;
        if (dev_mode != M_ABORT) begin
          if (frame_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got 0x%0h expected no frame", dev_bits);
          end else begin
            check("frame_bits", dev_bits, frame_q.pop_front());
          end
        end
        dev_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every done/err pulse and tracks clock-inhibit timing.
  initial begin : monitor
    logic pd, pe, pclk;
    int   run, since;
    res_t r;
    pd = 1'b0; pe = 1'b0; pclk = 1'b0; run = 0; since = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pd = 1'b0; pe = 1'b0; pclk = 1'b0; run = 0;
        continue;
      end
      if (pd) check("done_width", tx_done, 0);
      if (pe) check("err_width", tx_err, 0);
      if (ps2_clk_oe) begin
        run++;
      end else if (pclk) begin
        check_near("inhibit_len", run, INH_EXP, 2);
        run = 0;
        since = 0;
      end else begin
        since++;
      end
      if (tx_done || tx_err) begin
        check("done_err_overlap", tx_done & tx_err, 0);
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pulse_unexpected: got done=%0b err=%0b expected none", tx_done, tx_err);
        end else begin
          r = res_q.pop_front();
          check("result_kind", tx_err ? K_ERR : K_DONE, r.kind);
          if (tx_err) check("oe_on_err", {ps2_clk_oe, ps2_data_oe}, 0);
          if (r.chk_to) check_near("timeout_latency", since, TO_EXP, 2);
        end
      end
      pd = tx_done;
      pe = tx_err;
      pclk = ps2_clk_oe;
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_seen", n < 20000, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_ready && !dev_busy && res_q.size() == 0 && frame_q.size() == 0) && n < 20000);
    check({name, "_complete"}, n < 20000, 1);
  endtask

  vec_t vecs[6];

  initial begin : stim
    int n;
    bit fail_expected;
    vecs[0] = '{d: 8'hED, par: 1'b1, mode: M_ACK,    nack: 0};
    vecs[1] = '{d: 8'h00, par: 1'b1, mode: M_ACK,    nack: 0};
    vecs[2] = '{d: 8'hFF, par: 1'b1, mode: M_ACK,    nack: 0};
    vecs[3] = '{d: 8'h01, par: 1'b0, mode: M_ACK,    nack: 0};
    vecs[4] = '{d: 8'hF4, par: 1'b0, mode: M_ACK,    nack: 1};
    vecs[5] = '{d: 8'hED, par: 1'b1, mode: M_SILENT, nack: 0};

    rst = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      dev_mode = vecs[i].mode;
      dev_nack_req += vecs[i].nack;
      if (vecs[i].mode != M_SILENT) begin
        frame_q.push_back({1'b1, vecs[i].par, vecs[i].d, 1'b0});
        if (vecs[i].nack != 0 && RETRY) frame_q.push_back({1'b1, vecs[i].par, vecs[i].d, 1'b0});
      end
      fail_expected = (vecs[i].mode == M_SILENT) || (vecs[i].nack != 0 && !RETRY);
      res_q.push_back('{kind: fail_expected ? K_ERR : K_DONE, chk_to: vecs[i].mode == M_SILENT});
      @(negedge clk);
      send(vecs[i].d);
      wait_done($sformatf("vec%0d", i));
      if (vecs[i].mode == M_SILENT) begin
        repeat (100) @(negedge clk);
        check("silent_oe_after", {ps2_clk_oe, ps2_data_oe}, 0);
      end
      repeat (5) @(negedge clk);
    end

    // Back-to-back: valid held high, data changed while not ready.
    dev_mode = M_ACK;
    frame_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
    frame_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});
    res_q.push_back('{kind: K_DONE, chk_to: 1'b0});
    res_q.push_back('{kind: K_DONE, chk_to: 1'b0});
    @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'hF4;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < 20000);
    check("b2b_second_ready", n < 20000, 1);
    check("b2b_first_done_before_second", res_q.size(), 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    wait_done("b2b");
    repeat (5) @(negedge clk);

    // Reset in the middle of SHIFT.
    dev_mode = M_ABORT;
    @(negedge clk);
    send(8'h00);
    n = 0;
    while (!(dev_busy && dev_fe_cnt >= 3) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("abort_third_fe", n < 20000, 1);
    repeat (6) @(negedge clk);
    check("abort_data_oe_before", ps2_data_oe, 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_oe_async", {ps2_clk_oe, ps2_data_oe}, 0);
    n = 0;
    while (dev_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("abort_device_end", n < 20000, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_after", tx_ready, 1);
    check("abort_busy_after", busy, 0);
    repeat (20) @(negedge clk);
    check("leftover_results", res_q.size(), 0);
    check("leftover_frames", frame_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
